mshr_replay_issuer: RTL and testbench

- Dequeue-side consumer of the MSHR replay queue.
- After a refill completes, drains the queued secondary-miss requests and issues each to the cache replay pipeline with the refilled way's enable.
- Drops killed entries without issuing them, and frees the store-data-queue (SDQ) slot of every write it retires.
- Signals the owning MSHR when the queue is fully drained.

---
 rtl/mshr_replay_issuer.sv | 188 ++++++++++++++++++
 tb/tb_mshr_replay_issuer.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mshr_replay_issuer.sv
// Drains the MSHR replay queue into the cache replay pipeline after a refill.
// Optional saturating statistics counters are enabled with MSHR_REPLAY_STATS_EN.
module mshr_replay_issuer #(
  parameter int WAYS    = 4,
  parameter int STATS_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               io_start,
  input  logic [WAYS-1:0]    io_way_en,
  input  logic               io_rpq_valid,
  output logic               io_rpq_ready,
  input  logic [39:0]        io_rpq_bits_addr,
  input  logic [8:0]         io_rpq_bits_tag,
  input  logic [4:0]         io_rpq_bits_cmd,
  input  logic [2:0]         io_rpq_bits_typ,
  input  logic               io_rpq_bits_kill,
  input  logic               io_rpq_bits_phys,
  input  logic [4:0]         io_rpq_bits_sdq_id,
  output logic               io_replay_valid,
  input  logic               io_replay_ready,
  output logic [39:0]        io_replay_bits_addr,
  output logic [8:0]         io_replay_bits_tag,
  output logic [4:0]         io_replay_bits_cmd,
  output logic [2:0]         io_replay_bits_typ,
  output logic               io_replay_bits_phys,
  output logic [4:0]         io_replay_bits_sdq_id,
  output logic [WAYS-1:0]    io_replay_bits_way_en,
  output logic               io_sdq_free_valid,
  output logic [4:0]         io_sdq_free_id,
  output logic               io_busy,
  output logic               io_done,
  output logic [STATS_W-1:0] io_stat_issued,
  output logic [STATS_W-1:0] io_stat_killed
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } state_e;

  // Stores and AMOs carry data in the SDQ.
  function automatic logic is_write_f(input logic [4:0] cmd);
    return (cmd == 5'b00001) | cmd[3];
  endfunction

  state_e            state_r;
  logic              out_valid_r;
  logic              out_kill_r;
  logic              out_write_r;
  logic [39:0]       out_addr_r;
  logic [8:0]        out_tag_r;
  logic [4:0]        out_cmd_r;
  logic [2:0]        out_typ_r;
  logic              out_phys_r;
  logic [4:0]        out_sdq_id_r;
  logic [WAYS-1:0]   way_en_r;

  logic drain_s;
  logic rpq_ready_s;
  logic pop_s;

  // Killed entries leave the register without waiting for the pipeline.
  assign drain_s     = out_valid_r & (out_kill_r | io_replay_ready);
  // Gated by reset so nothing is popped or freed while aborting.
  assign rpq_ready_s = ~reset & (state_r == ACTIVE) & (~out_valid_r | drain_s);
  assign pop_s       = rpq_ready_s & io_rpq_valid;

  assign io_rpq_ready          = rpq_ready_s;
  assign io_replay_valid       = ~reset & out_valid_r & ~out_kill_r;
  assign io_replay_bits_addr   = out_addr_r;
  assign io_replay_bits_tag    = out_tag_r;
  assign io_replay_bits_cmd    = out_cmd_r;
  assign io_replay_bits_typ    = out_typ_r;
  assign io_replay_bits_phys   = out_phys_r;
  assign io_replay_bits_sdq_id = out_sdq_id_r;
  assign io_replay_bits_way_en = way_en_r;
  assign io_sdq_free_valid     = ~reset & drain_s & out_write_r;
  assign io_sdq_free_id        = out_sdq_id_r;
  assign io_busy               = (state_r != IDLE);
  assign io_done               = (state_r == DONE);

  // Drain FSM plus output-register occupancy and captured way enable.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      out_valid_r <= 1'b0;
      way_en_r    <= {WAYS{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (io_start) begin
            state_r  <= ACTIVE;
            way_en_r <= io_way_en;
          end else begin
            state_r  <= IDLE;
          end
        end
        ACTIVE: begin
          if (!io_rpq_valid && !out_valid_r) begin
            state_r <= DONE;
          end else begin
            state_r <= ACTIVE;
          end
        end
        DONE:    state_r <= IDLE;
        default: state_r <= IDLE;
      endcase

      if (pop_s) begin
        out_valid_r <= 1'b1;
      end else if (drain_s) begin
        out_valid_r <= 1'b0;
      end else begin
        out_valid_r <= out_valid_r;
      end
    end
  end

  // Output register payload, loaded on every pop and held while stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_kill_r   <= 1'b0;
      out_write_r  <= 1'b0;
      out_addr_r   <= 40'd0;
      out_tag_r    <= 9'd0;
      out_cmd_r    <= 5'd0;
      out_typ_r    <= 3'd0;
      out_phys_r   <= 1'b0;
      out_sdq_id_r <= 5'd0;
    end else if (pop_s) begin
      out_kill_r   <= io_rpq_bits_kill;
      out_write_r  <= is_write_f(io_rpq_bits_cmd);
      out_addr_r   <= io_rpq_bits_addr;
      out_tag_r    <= io_rpq_bits_tag;
      out_cmd_r    <= io_rpq_bits_cmd;
      out_typ_r    <= io_rpq_bits_typ;
      out_phys_r   <= io_rpq_bits_phys;
      out_sdq_id_r <= io_rpq_bits_sdq_id;
    end else begin
      out_kill_r   <= out_kill_r;
      out_write_r  <= out_write_r;
      out_addr_r   <= out_addr_r;
      out_tag_r    <= out_tag_r;
      out_cmd_r    <= out_cmd_r;
      out_typ_r    <= out_typ_r;
      out_phys_r   <= out_phys_r;
      out_sdq_id_r <= out_sdq_id_r;
    end
  end

`ifdef MSHR_REPLAY_STATS_EN
  logic [STATS_W-1:0] stat_issued_r;
  logic [STATS_W-1:0] stat_killed_r;
  logic               issue_s;
  logic               kill_drop_s;

  assign issue_s     = io_replay_valid & io_replay_ready;
  assign kill_drop_s = ~reset & drain_s & out_kill_r;

  // Saturating counters that survive across drains; only reset clears them.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_issued_r <= {STATS_W{1'b0}};
      stat_killed_r <= {STATS_W{1'b0}};
    end else begin
      if (issue_s && !(&stat_issued_r)) begin
        stat_issued_r <= stat_issued_r + {{(STATS_W-1){1'b0}}, 1'b1};
      end else begin
        stat_issued_r <= stat_issued_r;
      end
      if (kill_drop_s && !(&stat_killed_r)) begin
        stat_killed_r <= stat_killed_r + {{(STATS_W-1){1'b0}}, 1'b1};
      end else begin
        stat_killed_r <= stat_killed_r;
      end
    end
  end

  assign io_stat_issued = stat_issued_r;
  assign io_stat_killed = stat_killed_r;
`else
  assign io_stat_issued = {STATS_W{1'b0}};
  assign io_stat_killed = {STATS_W{1'b0}};
`endif

endmodule

// File: tb/tb_mshr_replay_issuer.sv
// Directed bench for mshr_replay_issuer: a queue-level scoreboard checks every
// cycle, and each scenario pins timing with hand-computed literals.
module tb_mshr_replay_issuer;
  localparam int WAYS = 4;
  localparam int SW   = 16;
`ifdef MSHR_REPLAY_STATS_EN
  localparam bit STATS_ON = 1'b1;
`else
  localparam bit STATS_ON = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset = 1'b1;
  logic            io_start = 1'b0;
  logic [WAYS-1:0] io_way_en = 4'b0000;
  logic            io_rpq_valid = 1'b0;
  logic            io_rpq_ready;
  logic [39:0]     io_rpq_bits_addr = 40'd0;
  logic [8:0]      io_rpq_bits_tag = 9'd0;
  logic [4:0]      io_rpq_bits_cmd = 5'd0;
  logic [2:0]      io_rpq_bits_typ = 3'd0;
  logic            io_rpq_bits_kill = 1'b0;
  logic            io_rpq_bits_phys = 1'b0;
  logic [4:0]      io_rpq_bits_sdq_id = 5'd0;
  logic            io_replay_valid;
  logic            io_replay_ready = 1'b0;
  logic [39:0]     io_replay_bits_addr;
  logic [8:0]      io_replay_bits_tag;
  logic [4:0]      io_replay_bits_cmd;
  logic [2:0]      io_replay_bits_typ;
  logic            io_replay_bits_phys;
  logic [4:0]      io_replay_bits_sdq_id;
  logic [WAYS-1:0] io_replay_bits_way_en;
  logic            io_sdq_free_valid;
  logic [4:0]      io_sdq_free_id;
  logic            io_busy;
  logic            io_done;
  logic [SW-1:0]   io_stat_issued;
  logic [SW-1:0]   io_stat_killed;

  mshr_replay_issuer #(.WAYS(WAYS), .STATS_W(SW)) dut (
    .clk(clk), .reset(reset), .io_start(io_start), .io_way_en(io_way_en),
    .io_rpq_valid(io_rpq_valid), .io_rpq_ready(io_rpq_ready),
    .io_rpq_bits_addr(io_rpq_bits_addr), .io_rpq_bits_tag(io_rpq_bits_tag),
    .io_rpq_bits_cmd(io_rpq_bits_cmd), .io_rpq_bits_typ(io_rpq_bits_typ),
    .io_rpq_bits_kill(io_rpq_bits_kill), .io_rpq_bits_phys(io_rpq_bits_phys),
    .io_rpq_bits_sdq_id(io_rpq_bits_sdq_id),
    .io_replay_valid(io_replay_valid), .io_replay_ready(io_replay_ready),
    .io_replay_bits_addr(io_replay_bits_addr), .io_replay_bits_tag(io_replay_bits_tag),
    .io_replay_bits_cmd(io_replay_bits_cmd), .io_replay_bits_typ(io_replay_bits_typ),
    .io_replay_bits_phys(io_replay_bits_phys), .io_replay_bits_sdq_id(io_replay_bits_sdq_id),
    .io_replay_bits_way_en(io_replay_bits_way_en),
    .io_sdq_free_valid(io_sdq_free_valid), .io_sdq_free_id(io_sdq_free_id),
    .io_busy(io_busy), .io_done(io_done),
    .io_stat_issued(io_stat_issued), .io_stat_killed(io_stat_killed)
  );

  typedef struct packed {
    logic [39:0] addr;
    logic [8:0]  tag;
    logic [4:0]  cmd;
    logic [2:0]  typ;
    logic        kill;
    logic        phys;
    logic [4:0]  sdq;
  } ent_t;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, expv);
    end
  endtask

  function automatic ent_t mk(input logic [8:0] tag, input logic [4:0] cmd,
                              input logic kill, input logic [4:0] sdq);
    ent_t e;
    e.addr = 40'h00_8000_0000 + {31'd0, tag};
    e.tag  = tag;
    e.cmd  = cmd;
    e.typ  = 3'd3;
    e.kill = kill;
    e.phys = tag[0];
    e.sdq  = sdq;
    return e;
  endfunction

  function automatic logic [62:0] pk(input ent_t e);
    return {e.addr, e.tag, e.cmd, e.typ, e.phys, e.sdq};
  endfunction

  function automatic logic is_wr(input logic [4:0] cmd);
    return (cmd == 5'b00001) || cmd[3];
  endfunction

  // Producer-side replay queue owned by the driver.
  ent_t q[$];

  // Model state, owned by the compare process.
  ent_t        exp_rep[$];
  logic [4:0]  exp_free[$];
  logic [3:0]  exp_way = 4'b0000;
  int          cyc = 0, start_cyc = 0;
  int          first_rv_rel = -1, first_free_rel = -1, done_rel = -1;
  int          busy_n = 0, rep_n = 0, free_n = 0, done_tot = 0;
  int          issued_tot = 0, killed_tot = 0;
  logic        kpend = 1'b0, hs_pop = 1'b0, prev_stall = 1'b0, prev_done = 1'b0;
  logic [62:0] prev_pk = 63'd0;
  logic [3:0]  prev_way = 4'b0000;

  // Compare process: mid-cycle sampling against the queue-level model.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        chk("rst_rpq_ready", io_rpq_ready, 0);
        chk("rst_sdq_free", io_sdq_free_valid, 0);
        exp_rep.delete();
        exp_free.delete();
        hs_pop = 1'b0; prev_stall = 1'b0; prev_done = 1'b0;
        issued_tot = 0; killed_tot = 0; kpend = 1'b0;
      end else begin
        if (io_start && !io_busy) begin
          exp_way = io_way_en; start_cyc = cyc;
          first_rv_rel = -1; first_free_rel = -1; done_rel = -1;
          busy_n = 0; rep_n = 0; free_n = 0;
        end
        if (io_busy) busy_n++;
        if (!io_busy) chk("idle_no_pop", io_rpq_ready, 0);
        if (io_replay_valid && !io_replay_ready) chk("stall_no_pop", io_rpq_ready, 0);
        if (prev_stall) begin
          chk("stall_valid_held", io_replay_valid, 1);
          chk("stall_fields_stable", {io_replay_bits_addr, io_replay_bits_tag, io_replay_bits_cmd,
              io_replay_bits_typ, io_replay_bits_phys, io_replay_bits_sdq_id}, prev_pk);
          chk("stall_way_stable", io_replay_bits_way_en, prev_way);
        end
        if (io_replay_valid) begin
          chk("replay_expected", exp_rep.size() != 0, 1);
          if (exp_rep.size() != 0) begin
            chk("replay_fields", {io_replay_bits_addr, io_replay_bits_tag, io_replay_bits_cmd,
                io_replay_bits_typ, io_replay_bits_phys, io_replay_bits_sdq_id}, pk(exp_rep[0]));
            chk("replay_way_en", io_replay_bits_way_en, exp_way);
            if (io_replay_ready) void'(exp_rep.pop_front());
          end
          if (first_rv_rel < 0) first_rv_rel = cyc - start_cyc;
          if (io_replay_ready) rep_n++;
        end
        if (io_sdq_free_valid) begin
          chk("free_expected", exp_free.size() != 0, 1);
          if (exp_free.size() != 0) begin
            chk("free_id", io_sdq_free_id, exp_free[0]);
            void'(exp_free.pop_front());
          end
          if (first_free_rel < 0) first_free_rel = cyc - start_cyc;
          free_n++;
        end
        if (io_done) begin
          chk("done_single_cycle", prev_done, 0);
          chk("done_replays_drained", exp_rep.size(), 0);
          chk("done_frees_drained", exp_free.size(), 0);
          done_rel = cyc - start_cyc;
          done_tot++;
        end
        chk("stat_issued", io_stat_issued, STATS_ON ? issued_tot : 0);
        chk("stat_killed", io_stat_killed, STATS_ON ? killed_tot : 0);
        if (io_replay_valid && io_replay_ready) issued_tot++;
        if (kpend) killed_tot++;
        hs_pop = io_rpq_ready && io_rpq_valid;
        kpend  = hs_pop && io_rpq_bits_kill;
        if (hs_pop) begin
          if (!io_rpq_bits_kill)
            exp_rep.push_back(mk(io_rpq_bits_tag, io_rpq_bits_cmd, 1'b0, io_rpq_bits_sdq_id));
          if (is_wr(io_rpq_bits_cmd)) exp_free.push_back(io_rpq_bits_sdq_id);
        end
        prev_stall = io_replay_valid && !io_replay_ready;
        prev_pk    = {io_replay_bits_addr, io_replay_bits_tag, io_replay_bits_cmd,
                      io_replay_bits_typ, io_replay_bits_phys, io_replay_bits_sdq_id};
        prev_way   = io_replay_bits_way_en;
        prev_done  = io_done;
      end
    end
  end

  task automatic drive_rpq();
    io_rpq_valid = (q.size() != 0);
    if (q.size() != 0) begin
      io_rpq_bits_addr   = q[0].addr;
      io_rpq_bits_tag    = q[0].tag;
      io_rpq_bits_cmd    = q[0].cmd;
      io_rpq_bits_typ    = q[0].typ;
      io_rpq_bits_kill   = q[0].kill;
      io_rpq_bits_phys   = q[0].phys;
      io_rpq_bits_sdq_id = q[0].sdq;
    end
  endtask

  // Advance one cycle; inputs change #1 after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
    if (hs_pop && q.size() != 0) void'(q.pop_front());
    drive_rpq();
  endtask

  task automatic start(input logic [3:0] w);
    io_start = 1'b1; io_way_en = w;
    step();
    io_start = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc);
    int base;
    base = done_tot;
    for (int i = 0; i < max_cyc && done_tot == base; i++) step();
    chk("drain_completes", done_tot != base, 1);
  endtask

  initial begin
    reset = 1'b1;
    step(); step(); step();
    reset = 1'b0;
    chk("reset_rpq_ready", io_rpq_ready, 0);
    chk("reset_replay_valid", io_replay_valid, 0);
    chk("reset_sdq_free", io_sdq_free_valid, 0);
    chk("reset_busy", io_busy, 0);
    chk("reset_done", io_done, 0);
    chk("reset_way_en", io_replay_bits_way_en, 4'b0000);

    // Three loads at full throughput.
    q.push_back(mk(9'd1, 5'd0, 1'b0, 5'd0));
    q.push_back(mk(9'd2, 5'd0, 1'b0, 5'd0));
    q.push_back(mk(9'd3, 5'd0, 1'b0, 5'd0));
    drive_rpq();
    io_replay_ready = 1'b1;
    start(4'b0010);
    wait_done(40);
    chk("s1_first_replay_cycle", first_rv_rel, 2);
    chk("s1_replays", rep_n, 3);
    chk("s1_frees", free_n, 0);
    chk("s1_done_cycle", done_rel, 6);
    step(); step();
    chk("s1_idle_after", io_busy, 0);

    // Store stalled for four cycles, with a load queued behind it.
    q.push_back(mk(9'd5, 5'b00001, 1'b0, 5'd7));
    q.push_back(mk(9'd6, 5'd0, 1'b0, 5'd0));
    drive_rpq();
    io_replay_ready = 1'b0;
    start(4'b0100);
    step(); step(); step(); step();
    chk("s2_stalled_valid", io_replay_valid, 1);
    chk("s2_stalled_tag", io_replay_bits_tag, 9'd5);
    chk("s2_stalled_no_pop", io_rpq_ready, 0);
    chk("s2_stalled_no_free", io_sdq_free_valid, 0);
    step();
    io_replay_ready = 1'b1;
    wait_done(40);
    chk("s2_free_cycle", first_free_rel, 6);
    chk("s2_frees", free_n, 1);
    chk("s2_replays", rep_n, 2);
    chk("s2_done_cycle", done_rel, 9);
    step(); step();

    // Load, killed store, AMO from a fresh reset so the statistics are known.
    reset = 1'b1;
    step();
    reset = 1'b0;
    q.push_back(mk(9'd10, 5'd0, 1'b0, 5'd0));
    q.push_back(mk(9'd11, 5'b00001, 1'b1, 5'd3));
    q.push_back(mk(9'd12, 5'b01000, 1'b0, 5'd4));
    drive_rpq();
    io_replay_ready = 1'b1;
    start(4'b1000);
    wait_done(40);
    chk("s3_replays", rep_n, 2);
    chk("s3_first_free_cycle", first_free_rel, 3);
    chk("s3_frees", free_n, 2);
    chk("s3_done_cycle", done_rel, 6);
    step(); step();
    chk("s3_stat_issued", io_stat_issued, STATS_ON ? 2 : 0);
    chk("s3_stat_killed", io_stat_killed, STATS_ON ? 1 : 0);

    // Empty queue, with a second start while ACTIVE.
    start(4'b0100);
    chk("s4_busy_active", io_busy, 1);
    io_start = 1'b1; io_way_en = 4'b1000;
    step();
    io_start = 1'b0;
    wait_done(20);
    chk("s4_busy_cycles", busy_n, 2);
    chk("s4_done_cycle", done_rel, 2);
    chk("s4_replays", rep_n, 0);
    chk("s4_way_kept", io_replay_bits_way_en, 4'b0100);
    step(); step();
    chk("s4_idle_after", io_busy, 0);

    // Reset while the output register holds a stalled store.
    q.push_back(mk(9'd20, 5'b00001, 1'b0, 5'd9));
    q.push_back(mk(9'd21, 5'd0, 1'b0, 5'd0));
    drive_rpq();
    io_replay_ready = 1'b0;
    start(4'b0001);
    step();
    chk("s5_pre_reset_valid", io_replay_valid, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("s5_replay_valid", io_replay_valid, 0);
    chk("s5_busy", io_busy, 0);
    chk("s5_sdq_free", io_sdq_free_valid, 0);
    chk("s5_rpq_ready", io_rpq_ready, 0);
    chk("s5_no_pop_in_reset", q.size(), 1);
    chk("s5_stat_cleared", io_stat_issued, 0);
    q.delete();
    drive_rpq();
    step(); step();
    chk("s5_stays_idle", io_busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
